// File: rtl/calc_pkg.sv
// Shared encodings for the sequential calculator ALU: operation codes and FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Ops that run WIDTH iterations of the multi-cycle datapath instead of EXEC.
  function automatic logic needs_iter(input logic [1:0] op, input logic divisor_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
  endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per strobe.
// acc is the product upper half / partial remainder; shreg is multiplier -> product low / dividend -> quotient.
module calc_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] shreg_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    rem_sh    = {acc, shreg[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, opnd};
    // The subtraction only matters when rem_sh >= opnd, where the difference fits in WIDTH bits.
    rem_sub   = rem_sh[WIDTH-1:0] - opnd;
    acc_nxt   = acc;
    shreg_nxt = shreg;
    if (is_div) begin
      acc_nxt   = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
      shreg_nxt = {shreg[WIDTH-2:0], rem_ge};
    end else begin
      acc_nxt   = mul_sum[WIDTH:1];
      shreg_nxt = {mul_sum[0], shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      shreg <= '0;
      opnd  <= '0;
    end else if (load) begin
      acc   <= '0;
      shreg <= a;
      opnd  <= b;
    end else if (step) begin
      acc   <= acc_nxt;
      shreg <= shreg_nxt;
    end
  end

  assign hi = acc;
  assign lo = shreg;

endmodule

// File: rtl/calc_alu_seq.sv
// Sequential calculator ALU with start/busy/done handshake (add, sub, shift-add mul, restoring div).
// Define CALC_ALU_SAT_EN to saturate res on overflow (ADD/MUL -> all ones, SUB -> 0).
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] iter_lo;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_res;
  logic             r_ovf;
  logic             r_div0;

  // start is ignored during the done cycle even though the FSM is already back in IDLE.
  assign accept = (state == ST_IDLE) && start && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (needs_iter(op, num2 == '0)) begin
            state_nxt = ST_ITER;
            load      = 1'b1;
          end else begin
            state_nxt = ST_EXEC;
          end
        end
      end
      ST_EXEC: state_nxt = ST_IDLE;
      ST_ITER: begin
        step = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  calc_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (op_q == OP_DIV),
    .a      (num1),
    .b      (num2),
    .hi     (prod_hi),
    .lo     (iter_lo)
  );

  // Final result and flags from the latched operands; only registered in EXEC or FIN.
  always_comb begin
    sum    = {1'b0, a_q} + {1'b0, b_q};
    r_res  = '0;
    r_ovf  = 1'b0;
    r_div0 = 1'b0;
    case (op_q)
      OP_ADD: {r_ovf, r_res} = sum;
      OP_SUB: begin
        r_res = a_q - b_q;
        r_ovf = a_q < b_q;
      end
      OP_MUL: begin
        r_res = iter_lo;
        r_ovf = |prod_hi;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          r_res  = '1;
          r_div0 = 1'b1;
        end else begin
          r_res  = iter_lo;
        end
      end
      default: r_res = '0;
    endcase
`ifdef CALC_ALU_SAT_EN
    if (r_ovf) r_res = (op_q == OP_SUB) ? '0 : '1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      res  <= '0;
      ovf  <= 1'b0;
      div0 <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q <= op_e'(op);
        a_q  <= num1;
        b_q  <= num2;
        busy <= 1'b1;
        if (needs_iter(op, num2 == '0)) cnt <= CNT_W'(WIDTH);
      end
      if (step) cnt <= cnt - CNT_W'(1);
      if (state == ST_EXEC || state == ST_FIN) begin
        res  <= r_res;
        ovf  <= r_ovf;
        div0 <= r_div0;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
- Parametrised sequential successor to the calculator's combinational ALU.
- Operations: add, subtract, multiply and divide on WIDTH-bit unsigned operands.
- Multiply uses iterative shift-add; divide uses restoring division.
- Start/busy/done handshake; sits between the keypad/operand registers and the display driver.

Parameters:
- WIDTH, 16, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  0=ADD, 1=SUB, 2=MUL, 3=DIV.
- num1  in  WIDTH  operand A (dividend).
- num2  in  WIDTH  operand B (divisor).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; res/flags are valid from this cycle on.
- res  out  WIDTH  result, held until the next accepted start.
- ovf  out  1  carry (ADD), borrow (SUB), or nonzero upper product half (MUL); 0 for DIV.
- div0  out  1  DIV with num2==0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, res, ovf, div0 all 0; counter 0.
- States: IDLE, EXEC, ITER, FIN.
- IDLE: start=1 at edge k latches num1/num2/op, sets busy=1. Go to EXEC for ADD/SUB, or for DIV with num2==0. Otherwise go to ITER with counter=WIDTH.
- EXEC: computes res and flags at edge k+1; asserts done=1 and busy=0 in the same update; returns to IDLE.
  - ADD latency is 1 cycle: done high in the cycle following edge k+1.
- ITER: one partial step per cycle for WIDTH cycles, then FIN.
  - FIN registers res/flags, pulses done, clears busy, returns to IDLE.
  - MUL/DIV: done asserted at edge k+WIDTH+1.
- ADD: {ovf,res} = num1+num2 (WIDTH+1-bit sum).
- SUB: res = num1-num2 mod 2^WIDTH; ovf = (num1<num2).
- MUL: 2·WIDTH-bit product; res = low half; ovf = |high half.
- DIV: res = floor(num1/num2); remainder discarded; ovf=0.
- DIV with num2==0: res = all ones, div0=1, ovf=0, EXEC path (1-cycle latency).
- div0 cleared on every completed non-div0 operation.
- start while busy or during the done cycle: ignored, no queueing. start held high in IDLE re-triggers every time IDLE is reached.
- Operand/op changes after acceptance: no effect (latched copies used).
- done is never asserted without a preceding accepted start.
- rst_n low mid-operation aborts immediately; all outputs return to reset values.

Optional Feature:
- Macro: CALC_ALU_SAT_EN.
- Defined: when ovf=1, res saturates. ADD/MUL → all ones; SUB → 0. ovf still reports the event.
- Undefined: wrap-around results as specified above.
- DIV is unaffected either way.

Decomposition:
- Shared package calc_pkg holds:
  - op encodings OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL=2'd2, OP_DIV=2'd3.
  - state encodings ST_IDLE, ST_EXEC, ST_ITER, ST_FIN.
- One sub-module, calc_muldiv_iter:
  - holds the shift-add / restoring-divide datapath registers (accumulator, partial remainder, shifted operand).
  - driven by load/step strobes from the parent FSM.

Test Plan:
- WIDTH=16, num1=1, num2=1, op=ADD, start pulse → done exactly 1 cycle after acceptance edge, res=2, ovf=0, busy low after.
- num1=16'hFFFF, num2=1, ADD → res=0, ovf=1 (with SAT_EN: res=16'hFFFF); SUB 5−7 → res=16'hFFFE, ovf=1 (SAT_EN: res=0).
- MUL 300×300 → done at edge k+17, res=24464 (16'h5F90), ovf=1 (SAT_EN: res=16'hFFFF); MUL 200×300 → res=60000, ovf=0.
- DIV 1000/7 → res=142, ovf=0, div0=0 at edge k+17; DIV 5/0 → res=16'hFFFF, div0=1, done at edge k+1.
- Second start pulses during a MUL busy window → ignored: exactly one done, res from the first operands.
- rst_n low at iteration 8 of a DIV → busy, done, res, flags all 0 asynchronously; new ADD after release completes normally.
